// File: rtl/chnl_acc_buf.sv
// Column-serial channel accumulator: sums each of WID columns (HIT lanes) over
// CHNL channels in a WID-entry buffer and streams finished columns out.
module chnl_acc_buf #(
    parameter int DW_IN  = 32,
    parameter int DW_ACC = 40,
    parameter int HIT    = 56,
    parameter int WID    = 56,
    parameter int CHNL   = 64,
    parameter int SAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DW_IN*HIT-1:0]  data_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DW_ACC*HIT-1:0] data_o,
    output logic                  out_last,
    output logic                  frame_done,
    output logic                  ovf
);

    localparam int CW  = (WID  > 1) ? $clog2(WID)  : 1;
    localparam int CHW = (CHNL > 1) ? $clog2(CHNL) : 1;

    localparam logic [CW-1:0]     COL_LAST = CW'(WID - 1);
    localparam logic [CHW-1:0]    CH_LAST  = CHW'(CHNL - 1);
    localparam logic [DW_ACC-1:0] LANE_MAX = {1'b0, {(DW_ACC-1){1'b1}}};
    localparam logic [DW_ACC-1:0] LANE_MIN = {1'b1, {(DW_ACC-1){1'b0}}};

    logic [DW_ACC*HIT-1:0] col_buf [WID];

    logic [CW-1:0]         col_cnt;
    logic [CHW-1:0]        ch_cnt;
    logic [DW_ACC*HIT-1:0] rd_word;
    logic [DW_ACC*HIT-1:0] sum_word;
    logic [HIT-1:0]        lane_ovf;
    logic                  beat_ovf;
    logic                  first_ch;
    logic                  last_ch;
    logic                  last_col;
    logic                  accept;
    logic                  buf_we;

    assign first_ch = (ch_cnt == '0);
    assign last_ch  = (ch_cnt == CH_LAST);
    assign last_col = (col_cnt == COL_LAST);

    // Only the last-channel beat needs room in the output register.
    assign in_ready   = !clr && (!last_ch || !out_valid || out_ready);
    assign accept     = in_valid && in_ready && !rst;
    assign buf_we     = accept && !last_ch;
    assign frame_done = out_valid && out_ready && out_last;

    assign rd_word  = col_buf[col_cnt];
    assign beat_ovf = |lane_ovf;

    // Channel 0 adds to zero instead of the buffer, so a new frame overwrites
    // stale sums without a clear pass.
    for (genvar k = 0; k < HIT; k++) begin : g_lane
        logic [DW_ACC:0] ext_x;
        logic [DW_ACC:0] ext_b;
        logic [DW_ACC:0] lane_sum;

        assign ext_x = {{(DW_ACC+1-DW_IN){data_i[k*DW_IN+DW_IN-1]}},
                        data_i[k*DW_IN +: DW_IN]};
        assign ext_b = first_ch ? '0
                                : {rd_word[k*DW_ACC+DW_ACC-1], rd_word[k*DW_ACC +: DW_ACC]};
        assign lane_sum    = ext_x + ext_b;
        assign lane_ovf[k] = lane_sum[DW_ACC] ^ lane_sum[DW_ACC-1];
        assign sum_word[k*DW_ACC +: DW_ACC] =
            (lane_ovf[k] && (SAT != 0)) ? (lane_sum[DW_ACC] ? LANE_MIN : LANE_MAX)
                                        : lane_sum[DW_ACC-1:0];
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            col_buf[col_cnt] <= sum_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt   <= '0;
            ch_cnt    <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            data_o    <= '0;
            out_last  <= 1'b0;
        end else if (clr) begin
            col_cnt   <= '0;
            ch_cnt    <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (last_col) begin
                    col_cnt <= '0;
                    ch_cnt  <= last_ch ? '0 : ch_cnt + 1'b1;
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                end

                if (first_ch && (col_cnt == '0)) begin
                    ovf <= beat_ovf;
                end else if (beat_ovf) begin
                    ovf <= 1'b1;
                end

                // A load here overrides a same-cycle handoff clearing out_valid.
                if (last_ch) begin
                    out_valid <= 1'b1;
                    data_o    <= sum_word;
                    out_last  <= last_col;
                end
            end
        end
    end

endmodule

// File: tb/tb_chnl_acc_buf.sv
// Scoreboard bench for chnl_acc_buf: three small instances (12-bit sat,
// 9-bit sat, 9-bit wrap) share one input stream and are checked per column.
module tb_chnl_acc_buf;

    localparam int HIT   = 2;
    localparam int WID   = 3;
    localparam int CHNL  = 4;
    localparam int DW_IN = 8;
    localparam int TMO   = 200;

    typedef struct packed {
        logic [2:0][31:0] l0;
        logic [2:0][31:0] l1;
        logic             last;
        logic [2:0]       ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst, clr, in_valid, out_ready;
    logic [DW_IN*HIT-1:0] data_i;

    logic rdy_a, rdy_b, rdy_c;
    logic vld_a, vld_b, vld_c;
    logic last_a, last_b, last_c;
    logic fd_a, fd_b, fd_c;
    logic ovf_a, ovf_b, ovf_c;
    logic [12*HIT-1:0] dout_a;
    logic [9*HIT-1:0]  dout_b, dout_c;

    int a0, a1, b0, b1, c0, c1;
    assign a0 = int'($signed(dout_a[11:0]));
    assign a1 = int'($signed(dout_a[23:12]));
    assign b0 = int'($signed(dout_b[8:0]));
    assign b1 = int'($signed(dout_b[17:9]));
    assign c0 = int'($signed(dout_c[8:0]));
    assign c1 = int'($signed(dout_c[17:9]));

    int   n_chk  = 0;
    int   n_fail = 0;
    int   orm    = 0;
    exp_t sb [$];

    int macc [3][WID][HIT];
    bit movf [3];
    int m_ch, m_col;
    int wacc [3] = '{12, 9, 9};
    bit sats [3] = '{1'b1, 1'b1, 1'b0};

    always #5 clk = ~clk;

    chnl_acc_buf #(.DW_IN(DW_IN), .DW_ACC(12), .HIT(HIT), .WID(WID), .CHNL(CHNL), .SAT(1)) u_dut_a (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy_a), .data_i(data_i),
        .out_valid(vld_a), .out_ready(out_ready), .data_o(dout_a), .out_last(last_a),
        .frame_done(fd_a), .ovf(ovf_a));

    chnl_acc_buf #(.DW_IN(DW_IN), .DW_ACC(9), .HIT(HIT), .WID(WID), .CHNL(CHNL), .SAT(1)) u_dut_b (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy_b), .data_i(data_i),
        .out_valid(vld_b), .out_ready(out_ready), .data_o(dout_b), .out_last(last_b),
        .frame_done(fd_b), .ovf(ovf_b));

    chnl_acc_buf #(.DW_IN(DW_IN), .DW_ACC(9), .HIT(HIT), .WID(WID), .CHNL(CHNL), .SAT(0)) u_dut_c (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy_c), .data_i(data_i),
        .out_valid(vld_c), .out_ready(out_ready), .data_o(dout_c), .out_last(last_c),
        .frame_done(fd_c), .ovf(ovf_c));

    task automatic check(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int fix(input int s, input int w, input bit sat, output bit o);
        int mx, mn, span;
        mx   = (1 << (w - 1)) - 1;
        mn   = -(1 << (w - 1));
        span = 1 << w;
        o    = (s > mx) || (s < mn);
        if (!o) return s;
        if (sat) return (s > mx) ? mx : mn;
        return (((s - mn) % span) + span) % span + mn;
    endfunction

    task automatic model_reset();
        m_ch  = 0;
        m_col = 0;
        for (int i = 0; i < 3; i++) movf[i] = 1'b0;
        sb.delete();
    endtask

    task automatic model_accept(input int v0, input int v1);
        int   x [2];
        int   s, r;
        bit   o;
        exp_t e;
        e    = '0;
        x[0] = v0;
        x[1] = v1;
        for (int i = 0; i < 3; i++) begin
            if (m_ch == 0 && m_col == 0) movf[i] = 1'b0;
            for (int k = 0; k < HIT; k++) begin
                s = (m_ch == 0) ? x[k] : macc[i][m_col][k] + x[k];
                r = fix(s, wacc[i], sats[i], o);
                if (o) movf[i] = 1'b1;
                if (m_ch != CHNL - 1) macc[i][m_col][k] = r;
                if (k == 0) e.l0[i] = r;
                else        e.l1[i] = r;
            end
            e.ovf[i] = movf[i];
        end
        e.last = (m_col == WID - 1);
        if (m_ch == CHNL - 1) sb.push_back(e);
        if (m_col == WID - 1) begin
            m_col = 0;
            m_ch  = (m_ch == CHNL - 1) ? 0 : m_ch + 1;
        end else begin
            m_col++;
        end
    endtask

    // Entered and left at posedge+1; acceptance decided from in_ready at negedge.
    task automatic drive_beat(input int v0, input int v1);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        data_i   = {8'(v1), 8'(v0)};
        for (int t = 0; t < TMO && !done; t++) begin
            @(negedge clk);
            if (rdy_a) begin
                model_accept(v0, v1);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("beat_timeout", done, 1);
        in_valid = 1'b0;
    endtask

    task automatic send_beats(input int n, input int c);
        for (int i = 0; i < n; i++) drive_beat(c, c);
    endtask

    task automatic send_frame(input int kind, input int c);
        for (int ch = 0; ch < CHNL; ch++)
            for (int col = 0; col < WID; col++)
                if (kind == 1) drive_beat(col, ch);
                else           drive_beat(c, c);
    endtask

    task automatic drain();
        for (int t = 0; t < TMO && sb.size() > 0; t++) @(posedge clk);
        check("drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (orm)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = ~out_ready;
            endcase
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_ready && vld_a) begin
                check("vld_b", vld_b, 1);
                check("vld_c", vld_c, 1);
                if (sb.size() == 0) begin
                    check("spurious_out", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("a_lane0", a0, $signed(e.l0[0]));
                    check("a_lane1", a1, $signed(e.l1[0]));
                    check("b_lane0", b0, $signed(e.l0[1]));
                    check("b_lane1", b1, $signed(e.l1[1]));
                    check("c_lane0", c0, $signed(e.l0[2]));
                    check("c_lane1", c1, $signed(e.l1[2]));
                    check("a_last", last_a, e.last);
                    check("c_last", last_c, e.last);
                    check("a_frame_done", fd_a, e.last);
                    check("b_frame_done", fd_b, e.last);
                    if (e.last) begin
                        check("a_ovf", ovf_a, e.ovf[0]);
                        check("b_ovf", ovf_b, e.ovf[1]);
                        check("c_ovf", ovf_c, e.ovf[2]);
                    end
                end
            end else if (vld_a && !out_ready && sb.size() > 0) begin
                check("hold_lane0", a0, $signed(sb[0].l0[0]));
                check("hold_lane1", a1, $signed(sb[0].l1[0]));
                check("hold_last", last_a, sb[0].last);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        data_i    = '0;
        out_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", vld_a, 0);
        check("rst_data_a", dout_a, 0);
        check("rst_data_c", dout_c, 0);
        check("rst_in_ready", rdy_a, 1);
        check("rst_ovf", ovf_a, 0);
        check("rst_last", last_a, 0);
        check("rst_frame_done", fd_a, 0);
        @(posedge clk);
        #1;

        send_frame(0, 1);    drain();
        send_frame(0, -128); drain();
        send_frame(1, 0);    drain();
        send_frame(0, 127);  drain();
        send_frame(0, 1);    drain();
        send_frame(0, 2);
        send_frame(0, 3);    drain();

        // Backpressure: stall on the second last-channel beat.
        orm       = 1;
        out_ready = 1'b0;
        send_beats(WID * (CHNL - 1) + 1, 1);
        in_valid = 1'b1;
        data_i   = {8'd1, 8'd1};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_in_ready", rdy_a, 0);
            check("stall_out_valid", vld_a, 1);
            @(posedge clk);
            #1;
        end
        orm = 2;
        drive_beat(1, 1);
        drive_beat(1, 1);
        drain();
        orm = 0;
        @(posedge clk);
        #1;

        // Frame abort at ch 2 col 1.
        send_beats(WID * 2 + 1, 127);
        @(negedge clk);
        check("pre_clr_ovf_b", ovf_b, movf[1]);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        data_i   = {8'd127, 8'd127};
        clr      = 1'b1;
        @(negedge clk);
        check("clr_in_ready", rdy_a, 0);
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        model_reset();
        @(negedge clk);
        check("clr_ovf_b", ovf_b, 0);
        check("clr_out_valid", vld_a, 0);
        @(posedge clk);
        #1;
        send_frame(0, 1); drain();

        // Reset mid-frame with a column pending in the output register.
        orm       = 1;
        out_ready = 1'b0;
        send_beats(WID * (CHNL - 1) + 1, 2);
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("mid_rst_out_valid", vld_a, 0);
        check("mid_rst_data", dout_a, 0);
        check("mid_rst_last", last_a, 0);
        orm       = 0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send_frame(0, 1); drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
